// File: rtl/cmd_mem_loader.sv
// cmd_mem_loader
//   Packs a narrow valid/ready word stream into full-width commands and writes
//   them to consecutive addresses of one selected command-memory bank.
//   Words are packed LSB chunk first: word k lands in cmd_write[MEM_WIDTH*k +: MEM_WIDTH].
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   start/start_core/start_addr/cmd_count   load request (sampled in IDLE only)
//   abort                       cancel the load in progress (LOAD only)
//   in_data/in_valid/in_ready   word stream handshake
//   cmd_write/cmd_write_addr/cmd_write_enable   registered bank write port
//   busy, done, error           status (done/error are one-cycle pulses)
//   checksum                    XOR of accepted words, only when built with
//                               CMD_LOADER_CHECKSUM_EN; otherwise tied to 0
module cmd_mem_loader #(
  parameter int N_CORES        = 4,
  parameter int CORE_SEL_WIDTH = 2,
  parameter int MEM_WIDTH      = 32,
  parameter int MEM_TO_CMD     = 4,
  parameter int CMD_ADDR_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [CORE_SEL_WIDTH-1:0]       start_core,
  input  logic [CMD_ADDR_WIDTH-1:0]       start_addr,
  input  logic [CMD_ADDR_WIDTH-1:0]       cmd_count,
  input  logic                            abort,
  input  logic [MEM_WIDTH-1:0]            in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [MEM_WIDTH*MEM_TO_CMD-1:0] cmd_write,
  output logic [CMD_ADDR_WIDTH-1:0]       cmd_write_addr,
  output logic [N_CORES-1:0]              cmd_write_enable,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [MEM_WIDTH-1:0]            checksum
);
  localparam int CMD_WIDTH = MEM_WIDTH * MEM_TO_CMD;
  localparam int CW        = (MEM_TO_CMD > 1) ? $clog2(MEM_TO_CMD) : 1;
  localparam logic [CW-1:0]             LAST_CHUNK = CW'(MEM_TO_CMD - 1);
  localparam logic [CW-1:0]             CHUNK_ONE  = CW'(1);
  localparam logic [CMD_ADDR_WIDTH-1:0] ADDR_ONE   = CMD_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                               state_q, state_d;
  logic [CORE_SEL_WIDTH-1:0]            core_q, core_d;
  logic [CMD_ADDR_WIDTH-1:0]            addr_q, addr_d;   // address of next write
  logic [CMD_ADDR_WIDTH-1:0]            rem_q, rem_d;     // commands still to write
  logic [CW-1:0]                        chunk_q, chunk_d;
  logic [MEM_TO_CMD-1:0][MEM_WIDTH-1:0] slot_q, slot_d;
  logic [CMD_WIDTH-1:0]                 cmd_write_q, cmd_write_d;
  logic [CMD_ADDR_WIDTH-1:0]            cmd_write_addr_q, cmd_write_addr_d;
  logic [N_CORES-1:0]                   we_q, we_d;
  logic                                 in_ready_q, in_ready_d;
  logic                                 busy_q, busy_d;
  logic                                 done_q, done_d;
  logic                                 error_q, error_d;
  logic                                 core_ok;

  assign core_ok = (32'(start_core) < N_CORES);

  always_comb begin
    state_d          = state_q;
    core_d           = core_q;
    addr_d           = addr_q;
    rem_d            = rem_q;
    chunk_d          = chunk_q;
    slot_d           = slot_q;
    cmd_write_d      = cmd_write_q;
    cmd_write_addr_d = cmd_write_addr_q;
    we_d             = '0;
    in_ready_d       = in_ready_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    error_d          = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!core_ok) begin
            error_d = 1'b1;
          end else begin
            core_d  = start_core;
            addr_d  = start_addr;
            rem_d   = cmd_count;
            chunk_d = '0;
            busy_d  = 1'b1;
            if (cmd_count == '0) begin
              // Empty load: done is raised on entry so DONE lasts one cycle.
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d    = LOAD;
              in_ready_d = 1'b1;
            end
          end
        end
      end
      LOAD: begin
        // in_ready is always high here, so in_valid alone is the handshake.
        if (abort) begin
          state_d    = IDLE;
          in_ready_d = 1'b0;
          busy_d     = 1'b0;
        end else if (in_valid) begin
          slot_d[chunk_q] = in_data;
          if (chunk_q == LAST_CHUNK) begin
            chunk_d          = '0;
            cmd_write_d      = slot_d;
            cmd_write_addr_d = addr_q;
            addr_d           = addr_q + ADDR_ONE;
            rem_d            = rem_q - ADDR_ONE;
            for (int i = 0; i < N_CORES; i++) we_d[i] = (32'(core_q) == i);
            if (rem_q == ADDR_ONE) begin
              state_d    = DONE;
              in_ready_d = 1'b0;
            end
          end else begin
            chunk_d = chunk_q + CHUNK_ONE;
          end
        end
      end
      DONE: begin
        // Entered on the final strobe with done low: spend one more cycle
        // pulsing done, then release busy.
        if (done_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      core_q           <= '0;
      addr_q           <= '0;
      rem_q            <= '0;
      chunk_q          <= '0;
      slot_q           <= '0;
      cmd_write_q      <= '0;
      cmd_write_addr_q <= '0;
      we_q             <= '0;
      in_ready_q       <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      core_q           <= core_d;
      addr_q           <= addr_d;
      rem_q            <= rem_d;
      chunk_q          <= chunk_d;
      slot_q           <= slot_d;
      cmd_write_q      <= cmd_write_d;
      cmd_write_addr_q <= cmd_write_addr_d;
      we_q             <= we_d;
      in_ready_q       <= in_ready_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      error_q          <= error_d;
    end
  end

`ifdef CMD_LOADER_CHECKSUM_EN
  logic [MEM_WIDTH-1:0] csum_q, csum_d;

  // Cleared by any accepted start (including empty loads), folded on every
  // accepted word; an aborting cycle accepts nothing.
  always_comb begin
    csum_d = csum_q;
    if (state_q == IDLE && start && core_ok)
      csum_d = '0;
    else if (state_q == LOAD && !abort && in_valid)
      csum_d = csum_q ^ in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  assign in_ready         = in_ready_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign cmd_write        = cmd_write_q;
  assign cmd_write_addr   = cmd_write_addr_q;
  assign cmd_write_enable = we_q;

endmodule

// File: tb/tb_cmd_mem_loader.sv
// Directed bench for cmd_mem_loader: a table of load requests with expected
// strobes/status, plus hand-written abort and mid-load reset sequences.
module tb_cmd_mem_loader;
  localparam int NC = 4, CSW = 3, MW = 32, MTC = 4, AW = 16;

  logic              clk = 1'b0;
  logic              reset, start, abort, in_valid;
  logic [CSW-1:0]    start_core;
  logic [AW-1:0]     start_addr, cmd_count;
  logic [MW-1:0]     in_data;
  logic              in_ready, busy, done, error;
  logic [MW*MTC-1:0] cmd_write;
  logic [AW-1:0]     cmd_write_addr;
  logic [NC-1:0]     cmd_write_enable;
  logic [MW-1:0]     checksum;

  cmd_mem_loader #(
    .N_CORES(NC), .CORE_SEL_WIDTH(CSW), .MEM_WIDTH(MW),
    .MEM_TO_CMD(MTC), .CMD_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_core(start_core),
    .start_addr(start_addr), .cmd_count(cmd_count), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cmd_write(cmd_write), .cmd_write_addr(cmd_write_addr),
    .cmd_write_enable(cmd_write_enable), .busy(busy), .done(done),
    .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: records every write strobe and done/error pulse.
  typedef struct {
    logic [NC-1:0]     we;
    logic [AW-1:0]     addr;
    logic [MW*MTC-1:0] data;
    int                c;
  } strobe_t;
  strobe_t     strobes[$];
  int          n_done, n_err, done_cyc, done_busy, busy_seen;
  logic [MW-1:0] done_csum;

  always @(negedge clk) begin
    if (cmd_write_enable != '0)
      strobes.push_back('{cmd_write_enable, cmd_write_addr, cmd_write, cyc});
    if (done) begin
      n_done++; done_cyc = cyc; done_busy = int'(busy); done_csum = checksum;
    end
    if (error) n_err++;
    if (busy) busy_seen = 1;
  end

  task automatic clear_mon();
    strobes.delete(); n_done = 0; n_err = 0; busy_seen = 0; done_cyc = -1;
  endtask

  function automatic logic [MW-1:0] wfn(int sel, int i);
    logic [MW-1:0] one;
    one = 1;
    return (sel == 0) ? 32'h11111111 * 32'(i + 1) : (one << i);
  endfunction

  function automatic logic [MW*MTC-1:0] ecmd(int sel, int j);
    logic [MW*MTC-1:0] r;
    r = '0;
    for (int k = 0; k < MTC; k++) r[k*MW +: MW] = wfn(sel, j*MTC + k);
    return r;
  endfunction

  typedef struct {
    logic [CSW-1:0] core;
    logic [AW-1:0]  addr;
    logic [AW-1:0]  cnt;
    int             stall;
    int             wsel;
    bit             busy_start;
    bit             exp_err;
    int             exp_n;
    logic [NC-1:0]  exp_we;
    bit             exp_done;
  } vec_t;
  vec_t vecs[9];

  task automatic run_vec(int idx, vec_t v);
    int P, acc3, nw;
    logic [MW-1:0] cs, ecs;
    bit rdy_ok;
    logic [AW-1:0] ea;
    clear_mon();
    @(negedge clk);
    start = 1; start_core = v.core; start_addr = v.addr; cmd_count = v.cnt;
    @(negedge clk);
    start = 0; P = cyc;
    if (v.exp_err) begin
      chk($sformatf("v%0d_error_t1", idx), error, 1);
      chk($sformatf("v%0d_busy_t1", idx), busy, 0);
    end else begin
      chk($sformatf("v%0d_busy_t1", idx), busy, 1);
      chk($sformatf("v%0d_csum_clear", idx), checksum, 0);
      if (v.cnt == 0) chk($sformatf("v%0d_done_t1", idx), done, 1);
      else            chk($sformatf("v%0d_ready_t1", idx), in_ready, 1);
    end
    nw = v.exp_err ? 0 : int'(v.cnt) * MTC;
    cs = '0; rdy_ok = 1; acc3 = -1;
    for (int i = 0; i < nw; i++) begin
      in_valid = 1; in_data = wfn(v.wsel, i); cs ^= in_data;
      if (!in_ready) rdy_ok = 0;
      if (v.busy_start && i == 2) begin
        start = 1; start_core = 0; start_addr = 16'h0055; cmd_count = 1;
      end
      if (i == MTC - 1) acc3 = cyc + 1;
      @(negedge clk);
      start = 0; in_valid = 0;
      repeat (v.stall) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    if (nw > 0) chk($sformatf("v%0d_ready_during_load", idx), rdy_ok, 1);
    chk($sformatf("v%0d_n_error", idx), n_err, v.exp_err);
    chk($sformatf("v%0d_n_strobe", idx), strobes.size(), v.exp_n);
    chk($sformatf("v%0d_n_done", idx), n_done, v.exp_done);
    for (int j = 0; j < strobes.size() && j < v.exp_n; j++) begin
      ea = v.addr + AW'(j);
      chk($sformatf("v%0d_s%0d_we", idx, j), strobes[j].we, v.exp_we);
      chk($sformatf("v%0d_s%0d_addr", idx, j), strobes[j].addr, ea);
      chk($sformatf("v%0d_s%0d_data", idx, j), strobes[j].data, ecmd(v.wsel, j));
    end
    if (v.exp_n > 0 && strobes.size() > 0) begin
      chk($sformatf("v%0d_strobe_after_4th", idx), strobes[0].c, acc3);
      if (v.stall == 0) chk($sformatf("v%0d_first_strobe_lat", idx), strobes[0].c, P + MTC);
      chk($sformatf("v%0d_done_after_strobe", idx), done_cyc, strobes[strobes.size()-1].c + 1);
    end
    if (v.exp_done) begin
      chk($sformatf("v%0d_busy_at_done", idx), done_busy, 1);
`ifdef CMD_LOADER_CHECKSUM_EN
      ecs = cs;
`else
      ecs = '0;
`endif
      chk($sformatf("v%0d_csum_at_done", idx), done_csum, ecs);
    end
    if (v.exp_err) chk($sformatf("v%0d_busy_never", idx), busy_seen, 0);
    chk($sformatf("v%0d_busy_end", idx), busy, 0);
    chk($sformatf("v%0d_ready_end", idx), in_ready, 0);
  endtask

  initial begin
    //           core  addr      cnt  stl sel bs err n  we       done
    vecs[0] = '{3'd2, 16'h0010, 16'd2, 0, 0, 1'b0, 1'b0, 2, 4'b0100, 1'b1};
    vecs[1] = '{3'd2, 16'h0010, 16'd2, 3, 0, 1'b0, 1'b0, 2, 4'b0100, 1'b1};
    vecs[2] = '{3'd1, 16'hFFFF, 16'd2, 0, 0, 1'b0, 1'b0, 2, 4'b0010, 1'b1};
    vecs[3] = '{3'd5, 16'h0010, 16'd2, 0, 0, 1'b0, 1'b1, 0, 4'b0000, 1'b0};
    vecs[4] = '{3'd4, 16'h0010, 16'd1, 0, 0, 1'b0, 1'b1, 0, 4'b0000, 1'b0};
    vecs[5] = '{3'd0, 16'h0040, 16'd0, 0, 0, 1'b0, 1'b0, 0, 4'b0000, 1'b1};
    vecs[6] = '{3'd3, 16'h0100, 16'd1, 0, 1, 1'b0, 1'b0, 1, 4'b1000, 1'b1};
    vecs[7] = '{3'd2, 16'h0010, 16'd2, 0, 0, 1'b1, 1'b0, 2, 4'b0100, 1'b1};
    // load following the abort: must start from chunk 0
    vecs[8] = '{3'd1, 16'h0020, 16'd1, 0, 1, 1'b0, 1'b0, 1, 4'b0010, 1'b1};

    reset = 1; start = 0; abort = 0; in_valid = 0; in_data = '0;
    start_core = '0; start_addr = '0; cmd_count = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_error", {done, error}, 0);
    chk("rst_we", cmd_write_enable, 0);
    chk("rst_cmd_write", cmd_write, 0);
    chk("rst_addr", cmd_write_addr, 0);
    chk("rst_checksum", checksum, 0);
    reset = 0;

    for (int v = 0; v < 8; v++) run_vec(v, vecs[v]);

    // Abort after 6 words of a two-command load.
    clear_mon();
    @(negedge clk);
    start = 1; start_core = 2; start_addr = 16'h0010; cmd_count = 2;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_data = wfn(0, i);
      @(negedge clk);
    end
    in_valid = 0; abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_ready_next", in_ready, 0);
    chk("abort_busy_next", busy, 0);
    repeat (4) @(negedge clk);
    chk("abort_n_strobe", strobes.size(), 1);
    chk("abort_n_done", n_done, 0);
    if (strobes.size() > 0) begin
      chk("abort_s0_addr", strobes[0].addr, 16'h0010);
      chk("abort_s0_data", strobes[0].data, ecmd(0, 0));
    end
    run_vec(8, vecs[8]);

    // Reset landing on the edge that accepts the last chunk kills the strobe.
    clear_mon();
    @(negedge clk);
    start = 1; start_core = 0; start_addr = 16'h0030; cmd_count = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < MTC; i++) begin
      in_valid = 1; in_data = wfn(0, i);
      if (i == MTC - 1) reset = 1;
      @(negedge clk);
    end
    in_valid = 0;
    chk("rst_mid_we", cmd_write_enable, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", in_ready, 0);
    chk("rst_mid_cmd_write", cmd_write, 0);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("rst_mid_n_strobe", strobes.size(), 0);
    chk("rst_mid_n_done", n_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
